// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one 64-bit RAM port between instruction fetch (read-only)
// and the load/store unit. Define ARB_RR_EN for round-robin instead of MEM priority.
module ram_port_arbiter #(
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [63:0] if_addr,
  output logic        if_ready,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [63:0] mem_addr,
  input  logic [63:0] mem_wdata,
  input  logic [63:0] mem_wmask,
  output logic        mem_ready,
  output logic        mem_rvalid,
  output logic [63:0] mem_rdata,
  output logic        ram_en,
  output logic        ram_we,
  output logic [63:0] ram_addr,
  output logic [63:0] ram_wdata,
  output logic [63:0] ram_wmask,
  input  logic [63:0] ram_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  typedef enum logic {OWN_IF, OWN_MEM} owner_t;

  state_t      state;
  owner_t      owner;
  logic        sel_hi;
  logic        wr_q;
  logic [31:0] if_rdata_q;
  logic [63:0] mem_rdata_q;
  logic [31:0] if_sel;
  logic [63:0] mem_sel;
  logic        grant_if;
  logic        grant_mem;
  logic        unused_bits;

`ifdef ARB_RR_EN
  owner_t last_owner;

  always_comb begin
    grant_mem = mem_req;
    grant_if  = if_req;
    if (if_req && mem_req) begin
      grant_mem = (last_owner == OWN_IF);
      grant_if  = (last_owner == OWN_MEM);
    end
  end
`else
  logic [7:0] starve_cnt;

  always_comb begin
    grant_mem = mem_req && !(if_req && (starve_cnt >= 8'(MAX_WAIT)));
    grant_if  = if_req && !grant_mem;
  end
`endif

  // Ready is decoded from the request inputs only; ram_rdata never reaches it.
  assign if_ready  = rst && (state == IDLE) && grant_if;
  assign mem_ready = rst && (state == IDLE) && grant_mem;

  assign if_sel    = sel_hi ? ram_rdata[63:32] : ram_rdata[31:0];
  assign mem_sel   = wr_q ? '0 : ram_rdata;
  // RAM data only exists during RESP, so the pulse cycle bypasses the hold register.
  assign if_rdata  = if_rvalid ? if_sel : if_rdata_q;
  assign mem_rdata = mem_rvalid ? mem_sel : mem_rdata_q;

  assign unused_bits = ^{if_addr[1:0], mem_addr[2:0]} ^ (MAX_WAIT == 0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      owner       <= OWN_IF;
      sel_hi      <= 1'b0;
      wr_q        <= 1'b0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      if_rvalid   <= 1'b0;
      mem_rvalid  <= 1'b0;
      ram_en      <= 1'b0;
      ram_we      <= 1'b0;
      ram_addr    <= '0;
      ram_wdata   <= '0;
      ram_wmask   <= '0;
`ifdef ARB_RR_EN
      last_owner  <= OWN_IF;
`else
      starve_cnt  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (grant_mem || grant_if) begin
            state  <= ISSUE;
            ram_en <= 1'b1;
            if (grant_mem) begin
              owner     <= OWN_MEM;
              wr_q      <= mem_we;
              ram_we    <= mem_we;
              ram_addr  <= {mem_addr[63:3], 3'b000};
              ram_wdata <= mem_wdata;
              ram_wmask <= mem_wmask;
            end else begin
              owner     <= OWN_IF;
              wr_q      <= 1'b0;
              sel_hi    <= if_addr[2];
              ram_we    <= 1'b0;
              ram_addr  <= {if_addr[63:3], 3'b000};
              ram_wdata <= '0;
              ram_wmask <= '0;
            end
`ifdef ARB_RR_EN
            last_owner <= grant_mem ? OWN_MEM : OWN_IF;
`else
            if (if_req && grant_mem) begin
              if (starve_cnt != 8'hFF) starve_cnt <= starve_cnt + 8'd1;
            end else if (grant_if) begin
              starve_cnt <= '0;
            end
`endif
          end
        end
        ISSUE: begin
          state      <= RESP;
          ram_en     <= 1'b0;
          ram_we     <= 1'b0;
          ram_addr   <= '0;
          ram_wdata  <= '0;
          ram_wmask  <= '0;
          if_rvalid  <= (owner == OWN_IF);
          mem_rvalid <= (owner == OWN_MEM);
        end
        RESP: begin
          state      <= IDLE;
          if_rvalid  <= 1'b0;
          mem_rvalid <= 1'b0;
          if (if_rvalid) if_rdata_q <= if_sel;
          if (mem_rvalid) mem_rdata_q <= mem_sel;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter: a word-array reference memory predicts responses,
// a per-cycle grant model checks arbitration, and monitors pop expectations on DUT strobes.
`timescale 1ns/1ps
module tb_ram_port_arbiter;
  localparam int unsigned MAX_WAIT = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [63:0] if_addr = '0;
  logic        if_ready, if_rvalid;
  logic [31:0] if_rdata;
  logic        mem_req = 1'b0, mem_we = 1'b0;
  logic [63:0] mem_addr = '0, mem_wdata = '0, mem_wmask = '0;
  logic        mem_ready, mem_rvalid;
  logic [63:0] mem_rdata;
  logic        ram_en, ram_we;
  logic [63:0] ram_addr, ram_wdata, ram_wmask;
  logic [63:0] ram_rdata = '0;

  always #5 clk = ~clk;

  ram_port_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_ready(mem_ready),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_wmask(ram_wmask), .ram_rdata(ram_rdata)
  );

  typedef struct { int cyc; logic we; logic [63:0] addr; logic [63:0] wdata; logic [63:0] wmask; } ram_exp_t;
  typedef struct { int cyc; logic [63:0] data; } rsp_exp_t;

  ram_exp_t    ram_q[$];
  rsp_exp_t    if_q[$];
  rsp_exp_t    mem_q[$];
  logic [63:0] ref_mem [1024];
  logic [63:0] ram_arr [1024];
  bit          written [1024];
  logic [31:0] last_if  = '0;
  logic [63:0] last_mem = '0;
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] init_word(input logic [9:0] i);
    return {32'hC0DE0000 + 32'(i), 32'h5A5A0000 ^ (32'(i) * 32'h101)};
  endfunction

  function automatic logic [63:0] ram_rd(input logic [9:0] i);
    return written[i] ? ram_arr[i] : init_word(i);
  endfunction

  // RAM: registered read; bus is garbage when not accessed.
  always @(posedge clk) begin
    if (ram_en) begin
      ram_rdata <= ram_rd(ram_addr[12:3]);
      if (ram_we) begin
        ram_arr[ram_addr[12:3]] <= (ram_rd(ram_addr[12:3]) & ~ram_wmask) | (ram_wdata & ram_wmask);
        written[ram_addr[12:3]] <= 1'b1;
      end
    end else begin
      ram_rdata <= {$urandom, $urandom};
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] rand_addr();
    return 64'h8000_0000 | (64'($urandom_range(0, 127)) << 3) | 64'($urandom_range(0, 7));
  endfunction

  task automatic do_if(input logic [63:0] addr, output int acc);
    int n;
    rsp_exp_t r;
    ram_exp_t m;
    logic [63:0] w;
    acc = -1;
    if_req = 1'b1;
    if_addr = addr;
    n = 0;
    @(negedge clk);
    while (!if_ready && n < 200) begin @(negedge clk); n++; end
    if (!if_ready) begin
      check("if_ready_timeout", 64'(if_ready), 64'd1);
    end else begin
      acc = cyc;
      w = ref_mem[addr[12:3]];
      r.cyc = cyc + 2;
      r.data = addr[2] ? {32'b0, w[63:32]} : {32'b0, w[31:0]};
      if_q.push_back(r);
      m.cyc = cyc + 1; m.we = 1'b0; m.addr = {addr[63:3], 3'b000}; m.wdata = '0; m.wmask = '0;
      ram_q.push_back(m);
    end
    @(posedge clk); #1;
    if_req = 1'b0;
  endtask

  task automatic do_mem(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                        input logic [63:0] wmask, output int acc);
    int n;
    rsp_exp_t r;
    ram_exp_t m;
    logic [63:0] w;
    acc = -1;
    mem_req = 1'b1; mem_we = we; mem_addr = addr; mem_wdata = wdata; mem_wmask = wmask;
    n = 0;
    @(negedge clk);
    while (!mem_ready && n < 200) begin @(negedge clk); n++; end
    if (!mem_ready) begin
      check("mem_ready_timeout", 64'(mem_ready), 64'd1);
    end else begin
      acc = cyc;
      w = ref_mem[addr[12:3]];
      r.cyc = cyc + 2;
      r.data = we ? 64'd0 : w;
      if (we) ref_mem[addr[12:3]] = (w & ~wmask) | (wdata & wmask);
      mem_q.push_back(r);
      m.cyc = cyc + 1; m.we = we; m.addr = {addr[63:3], 3'b000}; m.wdata = wdata; m.wmask = wmask;
      ram_q.push_back(m);
    end
    @(posedge clk); #1;
    mem_req = 1'b0;
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_ctl"}, {58'b0, if_ready, mem_ready, if_rvalid, mem_rvalid, ram_en, ram_we}, 64'd0);
    check({name, "_bus"}, ram_addr | ram_wdata | ram_wmask | mem_rdata | {32'b0, if_rdata}, 64'd0);
  endtask

  // Grant model: one accept, then two busy cycles; MEM priority with starvation bound.
  initial begin : arb_model
    int unsigned busy, starve;
    bit last_mem, eg_if, eg_mem;
    busy = 0; starve = 0; last_mem = 1'b0;
    forever begin
      @(negedge clk);
      if (cyc < 1) continue;
      if (!rst) begin
        busy = 0; starve = 0; last_mem = 1'b0;
        check("ready_in_reset", {62'b0, if_ready, mem_ready}, 64'd0);
      end else if (busy > 0) begin
        check("ready_while_busy", {62'b0, if_ready, mem_ready}, 64'd0);
        busy--;
      end else begin
`ifdef ARB_RR_EN
        eg_mem = (if_req && mem_req) ? !last_mem : mem_req;
`else
        eg_mem = mem_req && !(if_req && starve >= MAX_WAIT);
`endif
        eg_if = if_req && !eg_mem;
        check("grant", {62'b0, if_ready, mem_ready}, {62'b0, eg_if, eg_mem});
        if (eg_if || eg_mem) begin busy = 2; last_mem = eg_mem; end
        if (eg_mem && if_req) starve = (starve < 255) ? starve + 1 : 255;
        else if (eg_if) starve = 0;
      end
    end
  end

  initial begin : monitor
    ram_exp_t e;
    rsp_exp_t r;
    forever begin
      @(negedge clk);
      if (cyc < 1) continue;
      if (ram_en) begin
        if (ram_q.size() == 0) check("ram_en_unexpected", 64'(ram_en), 64'd0);
        else begin
          e = ram_q.pop_front();
          check("ram_cycle", 64'(cyc), 64'(e.cyc));
          check("ram_we", 64'(ram_we), 64'(e.we));
          check("ram_addr", ram_addr, e.addr);
          check("ram_wdata", ram_wdata, e.wdata);
          check("ram_wmask", ram_wmask, e.wmask);
        end
      end else begin
        check("ram_idle_zero", ram_addr | ram_wdata | ram_wmask | {63'b0, ram_we}, 64'd0);
      end
      if (if_rvalid) begin
        if (if_q.size() == 0) check("if_rvalid_unexpected", 64'(if_rvalid), 64'd0);
        else begin
          r = if_q.pop_front();
          check("if_rvalid_cycle", 64'(cyc), 64'(r.cyc));
          check("if_rdata", {32'b0, if_rdata}, r.data);
          last_if = r.data[31:0];
        end
      end else begin
        check("if_rdata_hold", {32'b0, if_rdata}, {32'b0, last_if});
      end
      if (mem_rvalid) begin
        if (mem_q.size() == 0) check("mem_rvalid_unexpected", 64'(mem_rvalid), 64'd0);
        else begin
          r = mem_q.pop_front();
          check("mem_rvalid_cycle", 64'(cyc), 64'(r.cyc));
          check("mem_rdata", mem_rdata, r.data);
          last_mem = r.data;
        end
      end else begin
        check("mem_rdata_hold", mem_rdata, last_mem);
      end
    end
  end

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int a0, a1, a2;
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(10'(i));
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset_state");
    @(posedge clk); #1;
    rst = 1'b1;

    // Instruction fetch of the upper half of a preloaded word
    do_mem(1'b1, 64'h8000_0000, 64'h1111_2222_3333_4444, '1, a0);
    do_if(64'h8000_0004, a0);
    repeat (3) @(negedge clk);
    check("t1_if_rdata", {32'b0, if_rdata}, 64'h1111_2222);
    @(posedge clk); #1;

    // MEM write then read back
    do_mem(1'b1, 64'h8000_1000, 64'hDEAD_BEEF_CAFE_F00D, '1, a0);
    do_mem(1'b0, 64'h8000_1000, 64'd0, 64'd0, a0);
    repeat (3) @(negedge clk);
    check("t2_mem_rdata", mem_rdata, 64'hDEAD_BEEF_CAFE_F00D);
    @(posedge clk); #1;

    // IF alone, held request: one accept every 3 cycles
    do_if(rand_addr(), a0);
    do_if(rand_addr(), a1);
    do_if(rand_addr(), a2);
    check("t6_spacing_1", 64'(a1 - a0), 64'd3);
    check("t6_spacing_2", 64'(a2 - a1), 64'd3);

    // Both requesting continuously
    fork
      begin int b; repeat (20) do_if(rand_addr(), b); end
      begin int c; repeat (60) do_mem(1'b0, rand_addr(), 64'd0, 64'd0, c); end
    join

    // Reset during the ISSUE cycle of a MEM read
    do_mem(1'b0, rand_addr(), 64'd0, 64'd0, a0);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    mem_q.delete();
    last_mem = '0;
    last_if = '0;
    @(negedge clk);
    check_all_zero("t5_after_reset");
    @(posedge clk); #1;
    do_mem(1'b0, 64'h8000_1000, 64'd0, 64'd0, a0);

    // Randomized mixed traffic with gaps
    fork
      begin
        int b;
        repeat (80) begin
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
          do_if(rand_addr(), b);
        end
      end
      begin
        int c;
        repeat (80) begin
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
          do_mem(1'($urandom_range(0, 1)), rand_addr(), {$urandom, $urandom}, {$urandom, $urandom}, c);
        end
      end
    join

    repeat (10) @(negedge clk);
    check("drain", 64'(if_q.size() + mem_q.size() + ram_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
